// File: rtl/rast_params.sv
// Shared rasterizer parameters: fixed-point widths, walker state encoding
// and the bit positions of the one-hot sub-sample step select.
package rast_params;

    localparam int SIGFIG = 24;
    localparam int RADIX  = 10;
    localparam int VERTS  = 3;
    localparam int AXIS   = 3;
    localparam int COLORS = 3;

    typedef enum logic {
        IDLE = 1'b0,
        WALK = 1'b1
    } walker_state_t;

    localparam int SS_BIT_1_0   = 3;
    localparam int SS_BIT_0_5   = 2;
    localparam int SS_BIT_0_25  = 1;
    localparam int SS_BIT_0_125 = 0;

endpackage

// File: rtl/sample_walker.sv
// Walks every grid sample inside a triangle's bounding box in x-major raster
// order, emitting one sample per downstream handshake.
module sample_walker
    import rast_params::*;
(
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [VERTS*AXIS*SIGFIG-1:0]     in_tri,
    input  logic [COLORS*SIGFIG-1:0]         in_color,
    input  logic [2*SIGFIG-1:0]              in_ll,
    input  logic [2*SIGFIG-1:0]              in_ur,
    input  logic [3:0]                       sub_sample,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [VERTS*AXIS*SIGFIG-1:0]     out_tri,
    output logic [COLORS*SIGFIG-1:0]         out_color,
    output logic [2*SIGFIG-1:0]              out_sample,
    output logic                             out_last
);

    localparam logic [SIGFIG-1:0] STEP_ONE = SIGFIG'(1) << RADIX;

    walker_state_t                       r_state;
    logic [VERTS*AXIS*SIGFIG-1:0]        r_tri;
    logic [COLORS*SIGFIG-1:0]            r_color;
    logic [SIGFIG-1:0]                   r_ll_x;
    logic [SIGFIG-1:0]                   r_ur_x;
    logic [SIGFIG-1:0]                   r_ur_y;
    logic [SIGFIG-1:0]                   r_x;
    logic [SIGFIG-1:0]                   r_y;
    logic [SIGFIG-1:0]                   r_step;

    walker_state_t                       w_state_next;
    logic [VERTS*AXIS*SIGFIG-1:0]        w_tri_next;
    logic [COLORS*SIGFIG-1:0]            w_color_next;
    logic [SIGFIG-1:0]                   w_ll_x_next;
    logic [SIGFIG-1:0]                   w_ur_x_next;
    logic [SIGFIG-1:0]                   w_ur_y_next;
    logic [SIGFIG-1:0]                   w_x_next;
    logic [SIGFIG-1:0]                   w_y_next;
    logic [SIGFIG-1:0]                   w_step_next;

    logic [SIGFIG-1:0]                   w_step_dec;
    logic [SIGFIG:0]                     w_x_sum;
    logic [SIGFIG:0]                     w_y_sum;
    logic                                w_x_over;
    logic                                w_y_over;
    logic                                w_walk;
    logic                                w_last;
    logic                                w_out_hs;
    logic                                w_accept;

    // Anything that is not exactly one-hot falls back to a full-pixel step.
    always_comb begin
        w_step_dec = STEP_ONE;
        if (sub_sample == (4'd1 << SS_BIT_0_5))
            w_step_dec = STEP_ONE >> 1;
        else if (sub_sample == (4'd1 << SS_BIT_0_25))
            w_step_dec = STEP_ONE >> 2;
        else if (sub_sample == (4'd1 << SS_BIT_0_125))
            w_step_dec = STEP_ONE >> 3;
    end

    // One extra bit keeps the comparison honest at the top of the range.
    assign w_x_sum  = {1'b0, r_x} + {1'b0, r_step};
    assign w_y_sum  = {1'b0, r_y} + {1'b0, r_step};
    assign w_x_over = w_x_sum > {1'b0, r_ur_x};
    assign w_y_over = w_y_sum > {1'b0, r_ur_y};

    assign w_walk   = (r_state == WALK);
    assign w_last   = w_walk & w_x_over & w_y_over;
    assign w_out_hs = w_walk & out_ready;
    assign w_accept = in_valid & in_ready;

    assign in_ready   = !w_walk | (w_out_hs & w_last);
    assign out_valid  = w_walk;
    assign out_last   = w_last;
    assign out_tri    = r_tri;
    assign out_color  = r_color;
    assign out_sample = {r_y, r_x};

    always_comb begin
        w_state_next = r_state;
        w_tri_next   = r_tri;
        w_color_next = r_color;
        w_ll_x_next  = r_ll_x;
        w_ur_x_next  = r_ur_x;
        w_ur_y_next  = r_ur_y;
        w_x_next     = r_x;
        w_y_next     = r_y;
        w_step_next  = r_step;

        if (w_accept) begin
            w_state_next = WALK;
            w_tri_next   = in_tri;
            w_color_next = in_color;
            w_ll_x_next  = in_ll[SIGFIG-1:0];
            w_ur_x_next  = in_ur[SIGFIG-1:0];
            w_ur_y_next  = in_ur[2*SIGFIG-1:SIGFIG];
            w_x_next     = in_ll[SIGFIG-1:0];
            w_y_next     = in_ll[2*SIGFIG-1:SIGFIG];
            w_step_next  = w_step_dec;
        end else if (w_out_hs) begin
            if (w_last) begin
                w_state_next = IDLE;
            end else if (!w_x_over) begin
                w_x_next = w_x_sum[SIGFIG-1:0];
            end else begin
                w_x_next = r_ll_x;
                w_y_next = w_y_sum[SIGFIG-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
            r_tri   <= '0;
            r_color <= '0;
            r_ll_x  <= '0;
            r_ur_x  <= '0;
            r_ur_y  <= '0;
            r_x     <= '0;
            r_y     <= '0;
            r_step  <= '0;
        end else begin
            r_state <= w_state_next;
            r_tri   <= w_tri_next;
            r_color <= w_color_next;
            r_ll_x  <= w_ll_x_next;
            r_ur_x  <= w_ur_x_next;
            r_ur_y  <= w_ur_y_next;
            r_x     <= w_x_next;
            r_y     <= w_y_next;
            r_step  <= w_step_next;
        end
    end

endmodule

// File: tb/tb_sample_walker.sv
// Directed bench for sample_walker: expected samples are queued when a
// triangle is sent and popped by a monitor on each output handshake.
module tb_sample_walker;
    import rast_params::*;

    localparam int TW = VERTS*AXIS*SIGFIG;
    localparam int CW = COLORS*SIGFIG;
    localparam int SW = 2*SIGFIG;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [TW-1:0] in_tri = '0;
    logic [CW-1:0] in_color = '0;
    logic [SW-1:0] in_ll = '0;
    logic [SW-1:0] in_ur = '0;
    logic [3:0]    sub_sample = 4'b1000;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [TW-1:0] out_tri;
    logic [CW-1:0] out_color;
    logic [SW-1:0] out_sample;
    logic          out_last;

    sample_walker dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_tri     (in_tri),
        .in_color   (in_color),
        .in_ll      (in_ll),
        .in_ur      (in_ur),
        .sub_sample (sub_sample),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_tri    (out_tri),
        .out_color  (out_color),
        .out_sample (out_sample),
        .out_last   (out_last)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [TW-1:0] tri_v;
        logic [CW-1:0] color;
        int            x;
        int            y;
        logic          last;
    } beat_t;

    beat_t exp_q[$];
    int    checks   = 0;
    int    errors   = 0;
    int    hs_count = 0;

    task automatic check(input string tag, input logic [TW-1:0] obs, input logic [TW-1:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic int step_of(input logic [3:0] ss);
        case (ss)
            4'b0100: return 512;
            4'b0010: return 256;
            4'b0001: return 128;
            default: return 1024;
        endcase
    endfunction

    // Queue the expected beats of a box; max_beats < 0 means the whole box.
    task automatic push_walk(input logic [TW-1:0] t, input logic [CW-1:0] c,
                             input int llx, input int lly, input int urx, input int ury,
                             input logic [3:0] ss, input int max_beats);
        int st = step_of(ss);
        int n  = 0;
        beat_t b;
        for (int y = lly; y <= ury; y += st) begin
            for (int x = llx; x <= urx; x += st) begin
                if (max_beats < 0 || n < max_beats) begin
                    b.tri_v = t;
                    b.color = c;
                    b.x     = x;
                    b.y     = y;
                    b.last  = (x + st > urx) && (y + st > ury);
                    exp_q.push_back(b);
                end
                n++;
            end
        end
    endtask

    task automatic drive_tri(input logic [TW-1:0] t, input logic [CW-1:0] c,
                             input int llx, input int lly, input int urx, input int ury,
                             input logic [3:0] ss);
        in_tri     = t;
        in_color   = c;
        in_ll      = {SIGFIG'(lly), SIGFIG'(llx)};
        in_ur      = {SIGFIG'(ury), SIGFIG'(urx)};
        sub_sample = ss;
        in_valid   = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string tag, input int max_cycles);
        int n = 0;
        @(negedge clk);
        while (out_valid && n < max_cycles) begin
            @(negedge clk);
            n++;
        end
        check(tag, TW'(out_valid), TW'(1'b0));
        #1;
    endtask

    always @(negedge clk) begin
        if (rst && out_valid && out_ready) begin
            beat_t b;
            hs_count++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL unexpected_beat: observed sample %0h expected none", out_sample);
            end else begin
                b = exp_q.pop_front();
                $display("beat %0d: x=%0d y=%0d last=%0b", hs_count,
                         out_sample[SIGFIG-1:0], out_sample[SW-1:SIGFIG], out_last);
                check("sample_x", TW'(out_sample[SIGFIG-1:0]), TW'(b.x));
                check("sample_y", TW'(out_sample[SW-1:SIGFIG]), TW'(b.y));
                check("last", TW'(out_last), TW'(b.last));
                check("tri", out_tri, b.tri_v);
                check("color", TW'(out_color), TW'(b.color));
            end
        end
    end

    localparam logic [TW-1:0] TRI_A = TW'(216'hA1A2A3);
    localparam logic [TW-1:0] TRI_B = TW'(216'hB1B2B3);
    localparam logic [TW-1:0] TRI_C = TW'(216'hC1C2C3);
    localparam logic [CW-1:0] COL_A = CW'(72'h0A0A);
    localparam logic [CW-1:0] COL_B = CW'(72'h0B0B);
    localparam logic [CW-1:0] COL_C = CW'(72'h0C0C);

    initial begin
        int hs0;

        // Reset state
        rst = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        check("rst_out_valid", TW'(out_valid), TW'(1'b0));
        check("rst_out_last", TW'(out_last), TW'(1'b0));
        check("rst_in_ready", TW'(in_ready), TW'(1'b1));
        check("rst_out_sample", TW'(out_sample), TW'(0));
        check("rst_out_tri", out_tri, TW'(0));
        check("rst_out_color", TW'(out_color), TW'(0));
        tick();
        rst = 1'b1;
        tick();

        // Basic walk: 6 samples on 6 consecutive cycles
        out_ready = 1'b1;
        drive_tri(TRI_A, COL_A, 0, 0, 2048, 1024, 4'b1000);
        push_walk(TRI_A, COL_A, 0, 0, 2048, 1024, 4'b1000, -1);
        tick();
        in_valid = 1'b0;
        hs0 = hs_count;
        repeat (6) tick();
        check("basic_count", TW'(hs_count - hs0), TW'(6));
        check("basic_idle", TW'(out_valid), TW'(1'b0));

        // Degenerate box with half-pixel step
        drive_tri(TRI_B, COL_B, 5120, 3072, 5120, 3072, 4'b0100);
        push_walk(TRI_B, COL_B, 5120, 3072, 5120, 3072, 4'b0100, -1);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        check("degen_valid", TW'(out_valid), TW'(1'b1));
        check("degen_last", TW'(out_last), TW'(1'b1));
        check("degen_in_ready", TW'(in_ready), TW'(1'b1));
        tick();
        check("degen_idle", TW'(out_valid), TW'(1'b0));

        // Backpressure: hold the second sample for 3 cycles
        drive_tri(TRI_A, COL_A, 0, 0, 2048, 1024, 4'b1000);
        push_walk(TRI_A, COL_A, 0, 0, 2048, 1024, 4'b1000, -1);
        tick();
        in_valid = 1'b0;
        tick();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_valid", TW'(out_valid), TW'(1'b1));
            check("stall_sample", TW'(out_sample), TW'({SIGFIG'(0), SIGFIG'(1024)}));
            check("stall_in_ready", TW'(in_ready), TW'(1'b0));
            #1;
        end
        tick();
        out_ready = 1'b1;
        wait_idle("stall_drain", 20);
        check("stall_queue", TW'(exp_q.size()), TW'(0));

        // Back-to-back: triangle C accepted on B's last handshake
        drive_tri(TRI_B, COL_B, 0, 0, 1024, 0, 4'b1000);
        push_walk(TRI_B, COL_B, 0, 0, 1024, 0, 4'b1000, -1);
        push_walk(TRI_C, COL_C, 2048, 0, 2048, 0, 4'b1000, -1);
        tick();
        drive_tri(TRI_C, COL_C, 2048, 0, 2048, 0, 4'b1000);
        @(negedge clk);
        check("b2b_busy_in_ready", TW'(in_ready), TW'(1'b0));
        tick();
        @(negedge clk);
        check("b2b_last_in_ready", TW'(in_ready), TW'(1'b1));
        check("b2b_last_flag", TW'(out_last), TW'(1'b1));
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        check("b2b_no_bubble", TW'(out_valid), TW'(1'b1));
        check("b2b_tri_switch", out_tri, TRI_C);
        #1;
        wait_idle("b2b_drain", 10);
        check("b2b_queue", TW'(exp_q.size()), TW'(0));

        // Fine step, reset after the 4th sample
        drive_tri(TRI_A, COL_A, 0, 0, 1024, 0, 4'b0001);
        push_walk(TRI_A, COL_A, 0, 0, 1024, 0, 4'b0001, 4);
        tick();
        in_valid = 1'b0;
        hs0 = hs_count;
        repeat (4) tick();
        rst = 1'b0;
        tick();
        check("fine_count", TW'(hs_count - hs0), TW'(4));
        check("fine_rst_valid", TW'(out_valid), TW'(1'b0));
        check("fine_rst_in_ready", TW'(in_ready), TW'(1'b1));
        check("fine_rst_sample", TW'(out_sample), TW'(0));
        rst = 1'b1;
        repeat (4) tick();
        check("fine_abandoned", TW'(out_valid), TW'(1'b0));
        check("final_queue", TW'(exp_q.size()), TW'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/sample_walker.md
SAMPLE_WALKER -- requirements
Module: sample_walker

Interface
REQ-001 SHALL take parameters from package rast_params: SIGFIG (24), RADIX (10), VERTS (3), AXIS (3), COLORS (3).
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst  in  1  synchronous, active-low reset.
REQ-004 in_valid  in  1  upstream triangle-plus-bounding-box valid.
REQ-005 in_ready  out  1  block accepts the upstream beat this cycle.
REQ-006 in_tri  in  VERTS*AXIS*SIGFIG  triangle vertex positions, fixed point with RADIX fraction bits.
REQ-007 in_color  in  COLORS*SIGFIG  triangle color.
REQ-008 in_ll / in_ur  in  2*SIGFIG each  bounding-box lower-left / upper-right corners {y,x}, unsigned, snapped to the sample grid.
REQ-009 sub_sample  in  4  one-hot step select: bit3=1.0, bit2=0.5, bit1=0.25, bit0=0.125 pixel.
REQ-010 out_valid  out  1  sample beat valid.
REQ-011 out_ready  in  1  downstream accepts the sample beat.
REQ-012 out_tri / out_color  out  as inputs  latched triangle and color for the current sample.
REQ-013 out_sample  out  2*SIGFIG  current sample position {y,x}.
REQ-014 out_last  out  1  high with the final sample of a triangle.

Function
REQ-015 States: IDLE and WALK.
REQ-016 IDLE: in_ready=1 and out_valid=0.
REQ-017 Accept (in_valid & in_ready) SHALL latch tri, color, ll, ur and step; set sample={ll_y,ll_x}; enter WALK.
REQ-018 Latency: the first sample SHALL be valid the cycle after acceptance.
REQ-019 Step: step = 1<<(RADIX-k), with k = 0, 1, 2, 3 for bits 3, 2, 1, 0 of sub_sample; a non-one-hot value SHALL decode as bit3 (step 1.0).
REQ-020 Order: x-major raster. Advance happens only on output handshake (out_valid & out_ready).
REQ-021 Advance rule when x+step <= ur_x: x += step.
REQ-022 Advance rule otherwise, when y+step <= ur_y: x = ll_x and y += step.
REQ-023 Advance rule otherwise: the current sample is last.
REQ-024 Compares SHALL use SIGFIG+1-bit sums so that no wrap-around occurs at the top of the coordinate range.
REQ-025 out_last = WALK & (x+step > ur_x) & (y+step > ur_y), evaluated on the current sample.
REQ-026 Stall: while out_valid & !out_ready, all outputs SHALL hold stable.
REQ-027 Last-sample handshake with in_valid=0: go to IDLE.
REQ-028 Back-to-back: in_ready SHALL also be high when the last sample handshakes in the same cycle. A new triangle accepted then SHALL produce its first sample on the next cycle, with no bubble.
REQ-029 Degenerate box (ll==ur): exactly one sample, with out_last=1.
REQ-030 Sample count per triangle SHALL be ((ur_x-ll_x)/step+1)*((ur_y-ll_y)/step+1).
REQ-031 in_ready SHALL be 0 during WALK except in the REQ-028 case.

Reset
REQ-032 rst=0 at a clock edge: state=IDLE, out_valid=0, out_last=0, in_ready=1 from the next cycle; out_sample, out_tri and out_color SHALL be 0.
REQ-033 Reset during WALK SHALL abandon the triangle; no further samples from it are emitted.

Structure
REQ-034 rast_params SHALL gain: the walker state enum typedef (IDLE, WALK) and the step-select bit positions.
REQ-035 The block SHALL be a single module with no sub-module; step decode and the advance logic are inline.

Verification
REQ-036 Basic walk. Stimulus: ll=(0,0), ur={y=1024, x=2048}, step 1.0, out_ready=1. Response: samples x,y = (0,0), (1024,0), (2048,0), (0,1024), (1024,1024), (2048,1024) on 6 consecutive cycles; out_last on the 6th only.
REQ-037 Degenerate box. Stimulus: ll=ur={3072,5120}, sub_sample=4'b0100. Response: one sample (5120,3072) with out_last=1; in_ready=1 in the same cycle.
REQ-038 Backpressure. Stimulus: REQ-036 setup with out_ready=0 for 3 cycles after the 2nd sample. Response: (1024,0) held stable for 3 cycles, then the sequence resumes unchanged.
REQ-039 Back-to-back. Stimulus: two triangles, with in_valid held through the last sample of the first. Response: the first sample of triangle 2 appears the cycle after triangle 1's last sample; out_tri switches at that point.
REQ-040 Fine step and reset. Stimulus: ll=(0,0), ur=(1024,0), sub_sample=4'b0001. Response: 9 samples spaced 128 apart. With rst=0 asserted after the 4th sample: out_valid=0 next cycle, state IDLE.
